ahb_slave_if_param: RTL and testbench

Parameterised AHB slave-side front end for the AHB-to-APB bridge.
- Decodes the address against a configurable N-region map and qualifies transfers.
- Pipelines address, write data and direction to a configurable depth, gated by HREADYin.
- Generates AHB-compliant two-cycle ERROR responses for unmapped accesses.
- Feeds the APB controller FSM and returns PRDATA on HRDATA.

---
 rtl/ahb_slave_if_param.sv | 124 ++++++++++++
 tb/tb_ahb_slave_if_param.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_if_param.sv
// AHB slave-side front end for the AHB-to-APB bridge: region decode, HREADYin-gated
// address/data pipeline and a two-cycle ERROR response for unmapped accesses.
`timescale 1ns/1ps
module ahb_slave_if_param #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 3,
  parameter int PIPE    = 2,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = {32'h8800_0000, 32'h8400_0000, 32'h8000_0000},
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = {3{32'hFC00_0000}}
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [ADDR_W-1:0]        HADDR,
  input  logic [DATA_W-1:0]        HWDATA,
  input  logic                     HWRITE,
  input  logic [1:0]               HTRANS,
  input  logic                     HREADYin,
  input  logic                     bridge_ready,
  input  logic [DATA_W-1:0]        PRDATA,
  output logic [DATA_W-1:0]        HRDATA,
  output logic [PIPE*ADDR_W-1:0]   HADDR_pipe,
  output logic [PIPE*DATA_W-1:0]   HWDATA_pipe,
  output logic                     HWRITEreg,
  output logic                     valid,
  output logic [NUM_SLV-1:0]       TEMP_SEL,
  output logic [1:0]               HRESP,
  output logic                     HREADYout,
  output logic [7:0]               err_cnt
);

  typedef enum logic [1:0] {ST_OKAY, ST_ERR1, ST_ERR2} state_t;

  state_t             state, state_nxt;
  logic               hit_any;
  logic               active;
  logic [NUM_SLV-1:0] sel;
  logic [ADDR_W-1:0]  addr_pipe [PIPE];
  logic [DATA_W-1:0]  data_pipe [PIPE];
  logic               trans_unused;

  // HTRANS[0] only separates SEQ from NONSEQ and IDLE from BUSY; neither matters here.
  assign trans_unused = HTRANS[0];

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Walk from the top index down so the lowest-index hit is the one that survives.
  always_comb begin
    sel     = '0;
    hit_any = 1'b0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((HADDR & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
          (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W])) begin
        sel     = NUM_SLV'(1) << i;
        hit_any = 1'b1;
      end
    end
  end

  assign TEMP_SEL = sel;
  assign active   = HREADYin & HTRANS[1];
  assign valid    = active & hit_any & (state != ST_ERR1);
  assign HRDATA   = PRDATA;

  // Pipeline stages: stage 1 captures the bus, later stages shift, all hold while HREADYin is low.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int k = 0; k < PIPE; k++) begin
        addr_pipe[k] <= '0;
        data_pipe[k] <= '0;
      end
      HWRITEreg <= 1'b0;
    end else if (HREADYin) begin
      addr_pipe[0] <= HADDR;
      data_pipe[0] <= HWDATA;
      for (int k = 1; k < PIPE; k++) begin
        addr_pipe[k] <= addr_pipe[k-1];
        data_pipe[k] <= data_pipe[k-1];
      end
      HWRITEreg <= HWRITE;
    end
  end

  for (genvar g = 0; g < PIPE; g++) begin : g_pack
    assign HADDR_pipe[g*ADDR_W +: ADDR_W]  = addr_pipe[g];
    assign HWDATA_pipe[g*DATA_W +: DATA_W] = data_pipe[g];
  end

  // Error response FSM
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state   <= ST_OKAY;
      err_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state == ST_ERR1) err_cnt <= sat_inc(err_cnt);
    end
  end

  always_comb begin
    state_nxt = state;
    HRESP     = 2'b00;
    HREADYout = bridge_ready;
    case (state)
      ST_OKAY: begin
        if (active && !hit_any) state_nxt = ST_ERR1;
      end
      ST_ERR1: begin
        HRESP     = 2'b01;
        HREADYout = 1'b0;
        state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP     = 2'b01;
        HREADYout = 1'b1;
        state_nxt = (active && !hit_any) ? ST_ERR1 : ST_OKAY;
      end
      default: state_nxt = ST_OKAY;
    endcase
  end

endmodule

// File: tb/tb_ahb_slave_if_param.sv
// Self-checking bench for ahb_slave_if_param: decode, pipeline, error FSM,
// saturation, read path and asynchronous reset.
`timescale 1ns/1ps
module tb_ahb_slave_if_param;
  localparam int ADDR_W = 32, DATA_W = 32, NUM_SLV = 3, PIPE = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [ADDR_W-1:0]      haddr;
  logic [DATA_W-1:0]      hwdata;
  logic                   hwrite;
  logic [1:0]             htrans;
  logic                   hreadyin;
  logic                   bridge_ready;
  logic [DATA_W-1:0]      prdata;
  logic [DATA_W-1:0]      hrdata;
  logic [PIPE*ADDR_W-1:0] haddr_pipe;
  logic [PIPE*DATA_W-1:0] hwdata_pipe;
  logic                   hwritereg;
  logic                   valid;
  logic [NUM_SLV-1:0]     temp_sel;
  logic [1:0]             hresp;
  logic                   hreadyout;
  logic [7:0]             err_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [31:0] a; logic [31:0] d; } xfer_t;
  typedef struct { logic [1:0] resp; logic rdy; } rsp_t;
  xfer_t xq[$];
  rsp_t  rq[$];

  ahb_slave_if_param dut (
    .HCLK(clk), .HRESET(rst), .HADDR(haddr), .HWDATA(hwdata), .HWRITE(hwrite),
    .HTRANS(htrans), .HREADYin(hreadyin), .bridge_ready(bridge_ready), .PRDATA(prdata),
    .HRDATA(hrdata), .HADDR_pipe(haddr_pipe), .HWDATA_pipe(hwdata_pipe),
    .HWRITEreg(hwritereg), .valid(valid), .TEMP_SEL(temp_sel), .HRESP(hresp),
    .HREADYout(hreadyout), .err_cnt(err_cnt)
  );

  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus;
    haddr = '0; hwdata = '0; hwrite = 1'b0; htrans = 2'b00;
  endtask

  task automatic test_reset;
    rst = 1'b1; idle_bus(); hreadyin = 1'b1; bridge_ready = 1'b1; prdata = '0;
    repeat (2) tick();
    checks++; if (hresp !== 2'b00) begin errors++; $display("FAIL reset_hresp got %b want 00", hresp); end
    checks++; if (hreadyout !== 1'b1) begin errors++; $display("FAIL reset_hreadyout got %b want 1", hreadyout); end
    checks++; if (haddr_pipe !== '0 || hwdata_pipe !== '0) begin errors++; $display("FAIL reset_pipes got %h/%h want 0", haddr_pipe, hwdata_pipe); end
    checks++; if (err_cnt !== 8'd0 || hwritereg !== 1'b0) begin errors++; $display("FAIL reset_cnt got %0d/%b want 0/0", err_cnt, hwritereg); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_decode;
    haddr = 32'h8400_0010; htrans = 2'b10; hreadyin = 1'b1; #1;
    checks++; if (temp_sel !== 3'b010 || valid !== 1'b1) begin errors++; $display("FAIL dec_r1 got %b/%b want 010/1", temp_sel, valid); end
    haddr = 32'h8000_0000; #1;
    checks++; if (temp_sel !== 3'b001 || valid !== 1'b1) begin errors++; $display("FAIL dec_base0 got %b/%b want 001/1", temp_sel, valid); end
    haddr = 32'h83FF_FFFF; #1;
    checks++; if (temp_sel !== 3'b001) begin errors++; $display("FAIL dec_top0 got %b want 001", temp_sel); end
    haddr = 32'h8BFF_FFFF; #1;
    checks++; if (temp_sel !== 3'b100) begin errors++; $display("FAIL dec_top2 got %b want 100", temp_sel); end
    haddr = 32'h8000_0000; htrans = 2'b01; #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL dec_busy got %b want 0", valid); end
    haddr = 32'h9000_0000; htrans = 2'b10; #1;
    checks++; if (temp_sel !== 3'b000 || valid !== 1'b0) begin errors++; $display("FAIL dec_miss got %b/%b want 000/0", temp_sel, valid); end
    idle_bus();
    tick();
  endtask

  task automatic test_pipeline;
    xfer_t x;
    idle_bus(); hreadyin = 1'b1;
    repeat (2) tick();
    haddr = 32'h8000_0004; hwdata = 32'hA5A5_0001; hwrite = 1'b1; htrans = 2'b10;
    xq.push_back('{a: haddr, d: hwdata});
    tick();
    x = xq.pop_front();
    checks++; if (haddr_pipe[31:0] !== x.a || hwdata_pipe[31:0] !== x.d) begin errors++; $display("FAIL pipe_s1 got %h/%h want %h/%h", haddr_pipe[31:0], hwdata_pipe[31:0], x.a, x.d); end
    checks++; if (haddr_pipe[63:32] !== 32'h0 || hwritereg !== 1'b1) begin errors++; $display("FAIL pipe_s2_early got %h/%b want 0/1", haddr_pipe[63:32], hwritereg); end
    xq.push_back(x);
    idle_bus(); hreadyin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (haddr_pipe[31:0] !== x.a || haddr_pipe[63:32] !== 32'h0 || hwritereg !== 1'b1) begin
        errors++; $display("FAIL pipe_stall%0d got %h/%h/%b want %h/0/1", i, haddr_pipe[31:0], haddr_pipe[63:32], hwritereg, x.a);
      end
    end
    hreadyin = 1'b1;
    tick();
    x = xq.pop_front();
    checks++; if (haddr_pipe[63:32] !== x.a || hwdata_pipe[63:32] !== x.d) begin errors++; $display("FAIL pipe_s2 got %h/%h want %h/%h", haddr_pipe[63:32], hwdata_pipe[63:32], x.a, x.d); end
    checks++; if (haddr_pipe[31:0] !== 32'h0 || hwritereg !== 1'b0) begin errors++; $display("FAIL pipe_s1_after got %h/%b want 0/0", haddr_pipe[31:0], hwritereg); end
  endtask

  task automatic test_error;
    rsp_t r;
    bridge_ready = 1'b1; hreadyin = 1'b1;
    haddr = 32'h9000_0000; htrans = 2'b10; #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL err_valid_req got %b want 0", valid); end
    rq.push_back('{resp: 2'b01, rdy: 1'b0});
    rq.push_back('{resp: 2'b01, rdy: 1'b1});
    rq.push_back('{resp: 2'b00, rdy: 1'b1});
    tick();
    idle_bus();
    for (int i = 0; i < 3; i++) begin
      #1;
      r = rq.pop_front();
      checks++; if (hresp !== r.resp || hreadyout !== r.rdy || valid !== 1'b0) begin
        errors++; $display("FAIL err_seq%0d got %b/%b/%b want %b/%b/0", i, hresp, hreadyout, valid, r.resp, r.rdy);
      end
      if (i < 2) tick();
    end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL err_cnt1 got %0d want 1", err_cnt); end
  endtask

  task automatic test_back_to_back;
    haddr = 32'h9000_0000; htrans = 2'b10;
    tick();
    checks++; if (hresp !== 2'b01) begin errors++; $display("FAIL b2b_err1 got %b want 01", hresp); end
    haddr = 32'h8000_0000; #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_err1_valid got %b want 0", valid); end
    haddr = 32'h9000_0000;
    tick();
    bridge_ready = 1'b0; #1;
    checks++; if (hresp !== 2'b01 || hreadyout !== 1'b1 || err_cnt !== 8'd2) begin
      errors++; $display("FAIL b2b_err2 got %b/%b/%0d want 01/1/2", hresp, hreadyout, err_cnt);
    end
    tick();
    checks++; if (hresp !== 2'b01 || hreadyout !== 1'b0 || err_cnt !== 8'd2) begin
      errors++; $display("FAIL b2b_reenter got %b/%b/%0d want 01/0/2", hresp, hreadyout, err_cnt);
    end
    tick();
    haddr = 32'h8400_0000; #1;
    checks++; if (valid !== 1'b1 || temp_sel !== 3'b010) begin errors++; $display("FAIL b2b_err2_valid got %b/%b want 1/010", valid, temp_sel); end
    tick();
    checks++; if (hresp !== 2'b00 || hreadyout !== 1'b0 || err_cnt !== 8'd3) begin
      errors++; $display("FAIL b2b_okay got %b/%b/%0d want 00/0/3", hresp, hreadyout, err_cnt);
    end
    bridge_ready = 1'b1;
    haddr = 32'h9000_0000; htrans = 2'b10;
    repeat (600) tick();
    idle_bus();
    repeat (3) tick();
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL err_sat got %0d want 255", err_cnt); end
  endtask

  task automatic test_read;
    prdata = 32'hDEAD_BEEF; #1;
    checks++; if (hrdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_beef got %h want deadbeef", hrdata); end
    prdata = 32'h0123_4567; #1;
    checks++; if (hrdata !== 32'h0123_4567) begin errors++; $display("FAIL rd_4567 got %h want 01234567", hrdata); end
    bridge_ready = 1'b0; #1;
    checks++; if (hreadyout !== 1'b0) begin errors++; $display("FAIL rd_notready got %b want 0", hreadyout); end
    bridge_ready = 1'b1; #1;
    checks++; if (hreadyout !== 1'b1) begin errors++; $display("FAIL rd_ready got %b want 1", hreadyout); end
  endtask

  task automatic test_reset_mid_err;
    hreadyin = 1'b1; bridge_ready = 1'b1;
    haddr = 32'h9000_0000; htrans = 2'b10;
    tick();
    idle_bus();
    checks++; if (hresp !== 2'b01 || hreadyout !== 1'b0) begin errors++; $display("FAIL mid_err_entry got %b/%b want 01/0", hresp, hreadyout); end
    #3 rst = 1'b1;
    #1;
    checks++; if (hresp !== 2'b00 || hreadyout !== 1'b1) begin errors++; $display("FAIL mid_err_rst got %b/%b want 00/1", hresp, hreadyout); end
    checks++; if (haddr_pipe !== '0 || hwdata_pipe !== '0 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL mid_err_clr got %h/%h/%0d want 0/0/0", haddr_pipe, hwdata_pipe, err_cnt);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_pipeline();
    test_error();
    test_back_to_back();
    test_read();
    test_reset_mid_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
